// File: rtl/control_unit_if.sv
// Bus bundle between the angstrom-cpu control unit and its memory, branch unit and datapath.
// The master side is the control unit; the slave side is whatever serves memory and consumes strobes.
interface control_unit_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        mem_data;
    logic              mem_ready;
    logic              branch;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [3:0]        op;
    logic [3:0]        operand;
    logic              ctrl_jmp;
    logic              ctrl_acc_ld;
    logic              ctrl_imm_sel;
    logic              ctrl_alu_sub;
    logic              ctrl_flags_ld;
    logic              ctrl_out_ld;
    logic [ADDR_W-1:0] pc;
    logic              halt;
    logic [1:0]        state;

    modport master (
        input  mem_data, mem_ready, branch,
        output mem_addr, mem_rd, mem_wr, op, operand, ctrl_jmp, ctrl_acc_ld,
               ctrl_imm_sel, ctrl_alu_sub, ctrl_flags_ld, ctrl_out_ld, pc, halt, state
    );

    modport slave (
        output mem_data, mem_ready, branch,
        input  mem_addr, mem_rd, mem_wr, op, operand, ctrl_jmp, ctrl_acc_ld,
               ctrl_imm_sel, ctrl_alu_sub, ctrl_flags_ld, ctrl_out_ld, pc, halt, state
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the angstrom-cpu core: owns PC and IR,
// issues memory requests and one-cycle control strobes per instruction.
module control_unit #(
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_BRZ = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_BRC = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [7:0]        ir_r;

    logic [3:0]        op_s;
    logic [3:0]        operand_s;
    logic [ADDR_W-1:0] operand_ext_s;
    logic              is_rd_op_s;
    logic              is_wr_op_s;
    logic              is_br_op_s;

    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_rd_s;
    logic              mem_wr_s;
    logic              jmp_s;
    logic              acc_ld_s;
    logic              imm_sel_s;
    logic              alu_sub_s;
    logic              flags_ld_s;
    logic              out_ld_s;
    logic              halt_s;

    // Split IR into fields and classify the opcode
    always_comb begin
        op_s          = ir_r[7:4];
        operand_s     = ir_r[3:0];
        operand_ext_s = ADDR_W'(operand_s);
        is_rd_op_s    = (op_s == OP_LDA) || (op_s == OP_ADD) || (op_s == OP_SUB);
        is_wr_op_s    = (op_s == OP_STA);
        is_br_op_s    = (op_s == OP_BRZ) || (op_s == OP_JMP) || (op_s == OP_BRC);
    end

    // Request and strobe generation from registered state, IR and the ready handshake
    always_comb begin
        mem_addr_s = pc_r;
        mem_rd_s   = 1'b0;
        mem_wr_s   = 1'b0;
        jmp_s      = 1'b0;
        acc_ld_s   = 1'b0;
        imm_sel_s  = 1'b0;
        alu_sub_s  = 1'b0;
        flags_ld_s = 1'b0;
        out_ld_s   = 1'b0;
        halt_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_rd_s = 1'b1;
            end
            ST_DECODE: begin
                mem_rd_s = 1'b0;
            end
            ST_EXEC: begin
                mem_addr_s = operand_ext_s;
                // Memory-op strobes fire only in the ready cycle so each is one cycle wide
                case (op_s)
                    OP_LDA: begin
                        mem_rd_s = 1'b1;
                        acc_ld_s = bus.mem_ready;
                    end
                    OP_STA: begin
                        mem_wr_s = 1'b1;
                    end
                    OP_ADD: begin
                        mem_rd_s   = 1'b1;
                        acc_ld_s   = bus.mem_ready;
                        flags_ld_s = bus.mem_ready;
                    end
                    OP_SUB: begin
                        mem_rd_s   = 1'b1;
                        acc_ld_s   = bus.mem_ready;
                        flags_ld_s = bus.mem_ready;
                        alu_sub_s  = bus.mem_ready;
                    end
                    OP_LDI: begin
                        acc_ld_s  = 1'b1;
                        imm_sel_s = 1'b1;
                    end
                    OP_OUT: begin
                        out_ld_s = 1'b1;
                    end
                    OP_BRZ, OP_JMP, OP_BRC: begin
                        jmp_s = 1'b1;
                    end
                    default: begin
                        jmp_s = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                halt_s = 1'b1;
            end
            default: begin
                halt_s = 1'b0;
            end
        endcase
    end

    // Drive the bus; reset silences every request and strobe immediately
    always_comb begin
        bus.mem_addr = mem_addr_s;
        bus.op       = op_s;
        bus.operand  = operand_s;
        bus.pc       = pc_r;
        bus.state    = state_r;
        if (rst) begin
            bus.mem_rd        = 1'b0;
            bus.mem_wr        = 1'b0;
            bus.ctrl_jmp      = 1'b0;
            bus.ctrl_acc_ld   = 1'b0;
            bus.ctrl_imm_sel  = 1'b0;
            bus.ctrl_alu_sub  = 1'b0;
            bus.ctrl_flags_ld = 1'b0;
            bus.ctrl_out_ld   = 1'b0;
            bus.halt          = 1'b0;
        end else begin
            bus.mem_rd        = mem_rd_s;
            bus.mem_wr        = mem_wr_s;
            bus.ctrl_jmp      = jmp_s;
            bus.ctrl_acc_ld   = acc_ld_s;
            bus.ctrl_imm_sel  = imm_sel_s;
            bus.ctrl_alu_sub  = alu_sub_s;
            bus.ctrl_flags_ld = flags_ld_s;
            bus.ctrl_out_ld   = out_ld_s;
            bus.halt          = halt_s;
        end
    end

    // Sequencer state, PC and IR update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            pc_r    <= {ADDR_W{1'b0}};
            ir_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_r    <= bus.mem_data;
                        pc_r    <= pc_r + ADDR_W'(1);
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_r <= (op_s == OP_HLT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_rd_op_s || is_wr_op_s) begin
                        if (bus.mem_ready) begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        // PC already points past this instruction; a taken branch overrides it
                        if (is_br_op_s && bus.branch) begin
                            pc_r <= operand_ext_s;
                        end
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the angstrom-cpu core. It owns the program counter and instruction register, fetches 8-bit instructions from memory, and decodes the 4-bit opcode. It drives the control strobes for the accumulator/ALU, memory and output register, and the `ctrl_jmp` line into the branch unit. It consumes the branch unit's `branch` decision to redirect the PC.

## Interface
- `ADDR_W`, default 4: PC and memory address width; the instruction operand field is 4 bits and is zero-extended to `ADDR_W`.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `mem_data_i` in 8: instruction or data word from memory; instruction format is `[7:4]` opcode, `[3:0]` operand.
- `mem_ready_i` in 1: memory completes the current read or write; sampled only while `mem_rd_o` or `mem_wr_o` is high.
- `branch_i` in 1: branch decision from the branch unit.
- `mem_addr_o` out ADDR_W: memory address; PC in FETCH, operand in EXEC.
- `mem_rd_o` out 1: read request.
- `mem_wr_o` out 1: write request; the accumulator drives the write data.
- `op_o` out 4: `IR[7:4]`; feeds the branch unit and the ALU.
- `operand_o` out 4: `IR[3:0]`.
- `ctrl_jmp_o` out 1: branch-evaluate strobe to the branch unit.
- `ctrl_acc_ld_o` out 1: accumulator load.
- `ctrl_imm_sel_o` out 1: accumulator source select; 1 selects `operand_o`, 0 selects the ALU/memory path.
- `ctrl_alu_sub_o` out 1: ALU operation; 1 = subtract, 0 = add/pass.
- `ctrl_flags_ld_o` out 1: Z/C flag register load.
- `ctrl_out_ld_o` out 1: output register load.
- `pc_o` out ADDR_W: current PC.
- `halt_o` out 1: high in HALT.
- `state_o` out 2: FETCH=0, DECODE=1, EXEC=2, HALT=3.

## Operation
- Opcodes:
  - 0000 LDA: acc ← mem[opnd].
  - 0001 STA: mem[opnd] ← acc.
  - 0010 ADD and 0011 SUB: acc ← acc ± mem[opnd], and flags load.
  - 0100 LDI: acc ← opnd.
  - 0101 OUT: out ← acc.
  - 0110 BRZ, 0111 JMP, 1000 BRC: branch class.
  - 1001–1110: NOP.
  - 1111 HLT.
- FETCH:
  - Drives `mem_rd_o=1` and `mem_addr_o=pc`.
  - On `mem_ready_i=1`: IR ← `mem_data_i`, pc ← pc+1 modulo 2^ADDR_W, and the state moves to DECODE.
  - Otherwise the state holds and the request stays stable.
- DECODE: one cycle with no strobes; `op_o` is valid for downstream decode. The next state is HALT for opcode 1111, otherwise EXEC.
- EXEC, memory ops (LDA/STA/ADD/SUB):
  - `mem_addr_o=operand`; `mem_rd_o=1` for LDA/ADD/SUB, `mem_wr_o=1` for STA.
  - The state holds until `mem_ready_i=1`.
  - In the ready cycle: `ctrl_acc_ld_o=1` for LDA/ADD/SUB, `ctrl_flags_ld_o=1` for ADD/SUB, and `ctrl_alu_sub_o=1` for SUB. Then the state moves to FETCH.
- EXEC, other ops (one cycle, then FETCH):
  - LDI: `ctrl_acc_ld_o=1` and `ctrl_imm_sel_o=1`.
  - OUT: `ctrl_out_ld_o=1`.
  - Branch class: `ctrl_jmp_o=1`; if `branch_i=1`, pc ← operand, otherwise pc is unchanged (already incremented).
  - NOP: no strobes.
- HALT: terminal state. All strobes and requests are 0 and `halt_o=1`. Only `rst_i` exits.
- The control unit does not qualify branch conditions; that is the branch unit's job. `branch_i` is ignored outside EXEC of a branch-class opcode.

## Timing
- Reset (synchronous, `rst_i` high at the edge):
  - pc=0, IR=0, state=FETCH.
  - Every strobe, `mem_rd_o` and `mem_wr_o` are 0 while `rst_i` is high.
  - `op_o=0`, `operand_o=0`, `halt_o=0`.
- Reset mid-operation aborts any outstanding memory request with no strobe issued.
- The first fetch request appears in the cycle after `rst_i` deasserts.
- Outputs are combinational from the registered state and IR. The register file and flags sample the strobes on the next edge.
- Latency with zero-wait memory (ready in the request cycle):
  - Non-memory instructions: 3 cycles (FETCH, DECODE, EXEC).
  - Memory instructions: 3 cycles.
  - Each wait cycle extends FETCH or EXEC by one.
- Every strobe is exactly one cycle wide per instruction.
- Memory handshake: `mem_rd_o`/`mem_wr_o` and `mem_addr_o` are held stable until and including the ready cycle. Ready arriving while no request is active is ignored. `mem_rd_o` and `mem_wr_o` are never high together.
- PC wrap: fetching from address 2^ADDR_W−1 sets pc=0.
- A taken branch overrides the increment. A branch to the instruction's own address is legal and loops.

## Test plan
- Reset, then memory returns 0x4A in one cycle: states 0→1→2→0; `ctrl_acc_ld_o` and `ctrl_imm_sel_o` pulse in the EXEC cycle; pc=1.
- JMP 0x79 at addr 0 with `branch_i=1`: `ctrl_jmp_o` pulses in EXEC and the next fetch uses `mem_addr_o=9`. BRZ 0x63 with `branch_i=0`: `ctrl_jmp_o=1` and the next fetch address is pc+1.
- ADD 0x25 with 2 wait cycles on the data read: `mem_rd_o=1` and `mem_addr_o=5` held for 3 cycles; `ctrl_acc_ld_o` and `ctrl_flags_ld_o` pulse once with `ctrl_alu_sub_o=0`. SUB 0x35: same behaviour with `ctrl_alu_sub_o=1`.
- STA 0x1C: `mem_wr_o=1` and `mem_addr_o=12` until ready; no acc strobe; `mem_rd_o=0` throughout.
- pc=15 fetching NOP 0x90: the next fetch address is 0. HLT 0xF0: `state_o=3` and `halt_o=1` held for 20 cycles regardless of `branch_i` or `mem_ready_i`.
- Assert `rst_i` while in EXEC of LDA waiting on memory: on the next edge state=0, pc=0, and all strobes and requests are 0; no `ctrl_acc_ld_o` is ever issued.
